// File: rtl/ailn_pkg.sv
// ailn_pkg: shared element width, vector sizing helpers and FSM encoding for the LayerNorm output packer.
package ailn_pkg;
    localparam int ELEM_W = 8;
    function automatic int n_elem(int dw);
        return dw / ELEM_W;
    endfunction
    function automatic int cnt_w(int dw);
        return $clog2(dw / ELEM_W) + 1;
    endfunction
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/ln_out_packer_if.sv
// ln_out_packer_if: serial element input and packed-vector valid/ready output of the packer.
interface ln_out_packer_if #(parameter int DATA_WIDTH = 192);
    import ailn_pkg::*;
    logic                     i_valid;
    logic signed [ELEM_W-1:0] i_data;
    logic                     i_done;
    logic                     o_valid;
    logic                     i_ready;
    logic [DATA_WIDTH-1:0]    o_data;
    modport master (output i_valid, i_data, i_done, i_ready, input o_valid, o_data);
    modport slave  (input i_valid, i_data, i_done, i_ready, output o_valid, o_data);
endinterface

// File: rtl/ln_pack_bank.sv
// ln_pack_bank: one packed-vector bank; optional LN_PACK_MAXABS_EN adds a running max |element|.
module ln_pack_bank
    import ailn_pkg::*;
#(parameter int DATA_WIDTH = 192) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic                            i_clr,
    input  logic                            i_we,
    input  logic [cnt_w(DATA_WIDTH)-1:0]    i_slot,
    input  logic signed [ELEM_W-1:0]        i_data,
    output logic [DATA_WIDTH-1:0]           o_data
`ifdef LN_PACK_MAXABS_EN
    ,
    output logic [7:0]                      o_maxabs
`endif
);
    localparam int N = n_elem(DATA_WIDTH);
    logic [DATA_WIDTH-1:0] nxt;
    // Writing a slot zeroes every later slot, so a flushed partial vector is already zero-filled.
    always_comb begin
        nxt = '0;
        for (int j = 0; j < N; j++)
            nxt[DATA_WIDTH-1-ELEM_W*j -: ELEM_W] = j < int'(i_slot) ? o_data[DATA_WIDTH-1-ELEM_W*j -: ELEM_W] :
                                                   (j == int'(i_slot) ? i_data : '0);
    end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            o_data <= '0;
        else if (i_clr)
            o_data <= '0;
        else if (i_we)
            o_data <= nxt;
    end
`ifdef LN_PACK_MAXABS_EN
    logic [7:0] mag;
    assign mag = i_data == -8'sd128 ? 8'd127 : (i_data[7] ? 8'(-i_data) : i_data);
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            o_maxabs <= '0;
        else if (i_clr)
            o_maxabs <= '0;
        else if (i_we)
            o_maxabs <= (i_slot == '0 || mag > o_maxabs) ? mag : o_maxabs;
    end
`endif
endmodule

// File: rtl/ln_out_packer.sv
// ln_out_packer: packs serial LayerNorm bytes MSB-first into double-banked vectors with valid/ready output.
// Optional LN_PACK_MAXABS_EN exposes o_maxabs for the bank being read.
module ln_out_packer
    import ailn_pkg::*;
#(parameter int DATA_WIDTH = 192) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic                            i_start,
    ln_out_packer_if.slave                  bus,
    output logic                            o_overflow,
    output logic [cnt_w(DATA_WIDTH)-1:0]    o_elem_cnt
`ifdef LN_PACK_MAXABS_EN
    ,
    output logic [7:0]                      o_maxabs
`endif
);
    localparam int N  = n_elem(DATA_WIDTH);
    localparam int CW = cnt_w(DATA_WIDTH);
    state_t state, state_n;
    logic [1:0] full, full_n;
    logic wr_ptr, wr_n, rd_ptr, rd_n, ovf_n, run, acc, fin, hs;
    logic [CW-1:0] cnt, cnt_n;
    logic [DATA_WIDTH-1:0] bank_q [2];
`ifdef LN_PACK_MAXABS_EN
    logic [7:0] max_q [2];
    assign o_maxabs = max_q[rd_ptr];
`endif
    assign bus.o_valid = full[rd_ptr];
    assign bus.o_data  = bank_q[rd_ptr];
    assign o_elem_cnt  = cnt;
    // A completion only targets the write bank and a handshake only the read bank, so both can apply.
    always_comb begin
        run     = state == RUN;
        acc     = run && bus.i_valid && !full[wr_ptr];
        hs      = bus.o_valid && bus.i_ready;
        fin     = (acc && cnt == CW'(N - 1)) || (run && bus.i_done && (acc || cnt != '0));
        state_n = state;
        full_n  = full;
        wr_n    = wr_ptr;
        rd_n    = rd_ptr;
        cnt_n   = cnt + CW'(acc);
        ovf_n   = o_overflow || (run && bus.i_valid && full[wr_ptr]);
        if (fin) begin
            full_n[wr_ptr] = 1'b1;
            wr_n           = !wr_ptr;
            cnt_n          = '0;
        end
        if (hs) begin
            full_n[rd_ptr] = 1'b0;
            rd_n           = !rd_ptr;
        end
        if (i_start) begin
            state_n = RUN;
            full_n  = '0;
            wr_n    = 1'b0;
            rd_n    = 1'b0;
            cnt_n   = '0;
            ovf_n   = 1'b0;
        end
    end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= IDLE;
            full       <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            cnt        <= '0;
            o_overflow <= 1'b0;
        end else begin
            state      <= state_n;
            full       <= full_n;
            wr_ptr     <= wr_n;
            rd_ptr     <= rd_n;
            cnt        <= cnt_n;
            o_overflow <= ovf_n;
        end
    end
    for (genvar b = 0; b < 2; b++) begin : g_bank
        ln_pack_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank (
            .i_clk    (i_clk),
            .i_rstn   (i_rstn),
            .i_clr    (i_start),
            .i_we     (acc && wr_ptr == 1'(b)),
            .i_slot   (cnt),
            .i_data   (bus.i_data),
            .o_data   (bank_q[b])
`ifdef LN_PACK_MAXABS_EN
            ,
            .o_maxabs (max_q[b])
`endif
        );
    end
endmodule
